dmem_responder: RTL and testbench

//  Data-memory responder for the RV32I core: target end of the core's load/store port. Decodes funct3 into

---
 rtl/cpe_mem_pkg.sv | 30 +++
 rtl/dmem_lane_align.sv | 59 +++++
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_dmem_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpe_mem_pkg.sv
// Shared encodings for the data-memory path: funct3 access codes, responder FSM states, alignment masks.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpe_mem_pkg;

    // funct3 access size / signedness codes used by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Low address bits that must be zero for a naturally aligned access
    localparam logic [1:0] HALF_ALIGN_MASK = 2'b01;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // True for the five funct3 codes that name a real access size
    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering for the data memory: store byte enables and replication, load lane extract and extension, alignment / funct3 checks.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the responder asks.
module dmem_lane_align
    import cpe_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] ram_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte and half-word out of the stored word
    assign lane_b = ram_word[{addr_lo, 3'b000} +: 8];
    assign lane_h = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];

    // Decode size/sign into enables, replicated store data and extended load data
    always_comb begin
        byte_en    = 4'b0000;
        store_word = store_data;
        load_data  = 32'd0;
        misaligned = 1'b0;
        illegal    = !f3_legal(funct3);
        case (funct3)
            F3_B, F3_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                store_word = {4{store_data[7:0]}};
                load_data  = (funct3 == F3_B) ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
                // Unsigned codes describe load extension only; as a store they are meaningless
                if (is_store && funct3 == F3_BU) illegal = 1'b1;
            end
            F3_H, F3_HU: begin
                misaligned = |(addr_lo & HALF_ALIGN_MASK);
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                load_data  = (funct3 == F3_H) ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
                if (is_store && funct3 == F3_HU) illegal = 1'b1;
            end
            F3_W: begin
                misaligned = |(addr_lo & WORD_ALIGN_MASK);
                byte_en    = 4'b1111;
                load_data  = ram_word;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store port: word RAM, lane steering, fault flagging; optional stats via DMEM_STATS_EN.
// Latency: request sampled at edge N gives a one-cycle ready in the cycle after edge N+WAIT_CYCLES.
// Backpressure: inputs ignored outside IDLE; requester holds rd/wr until ready, one access per WAIT_CYCLES+2 clocks.
module dmem_responder
    import cpe_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk_w_i,
    input  logic        res_w_i_h,
    input  logic [31:0] mem_addr_w_i,
    input  logic [31:0] mem_data_w_i,
    input  logic        mem_wr_w_i_h,
    input  logic        mem_rd_w_i_h,
    input  logic [2:0]  mem_funct3_w_i,
    output logic [31:0] mem_data_w_o,
    output logic        mem_ready_w_o_h,
    output logic        mem_fault_w_o_h,
    output logic        fault_sticky_w_o_h
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] rd_cnt_w_o,
    output logic [31:0] wr_cnt_w_o,
    output logic [31:0] fault_cnt_w_o
`endif
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

    state_t        state;
    logic [2:0]    wait_cnt;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic [2:0]    f3_q;
    logic          rd_q;
    logic          wr_q;

    logic          in_idle;
    logic          req;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_data;
    logic [2:0]    cur_f3;
    logic          cur_rd;
    logic          cur_wr;
    logic          enter_resp;
    logic          out_of_range;
    logic          access_fault;
    logic [AW-1:0] idx;
    logic [31:0]   ram_word;
    logic [3:0]    byte_en;
    logic [31:0]   store_word;
    logic [31:0]   load_data;
    logic          misaligned;
    logic          illegal;

    logic [31:0]   ram [DEPTH_WORDS];

    // With zero wait states the response is decided at the sampling edge, so the live inputs
    // stand in for the latched request while in IDLE.
    always_comb begin
        in_idle      = (state == S_IDLE);
        req          = mem_rd_w_i_h | mem_wr_w_i_h;
        cur_addr     = in_idle ? mem_addr_w_i   : addr_q;
        cur_data     = in_idle ? mem_data_w_i   : data_q;
        cur_f3       = in_idle ? mem_funct3_w_i : f3_q;
        cur_rd       = in_idle ? mem_rd_w_i_h   : rd_q;
        cur_wr       = in_idle ? mem_wr_w_i_h   : wr_q;
        enter_resp   = in_idle ? (req && (WAIT_CYCLES == 0))
                               : ((state == S_WAIT) && (wait_cnt == 3'd0));
        out_of_range = |cur_addr[31:AW+2];
        access_fault = misaligned | illegal | out_of_range | (cur_rd & cur_wr);
        idx          = cur_addr[AW+1:2];
        ram_word     = ram[idx];
    end

    dmem_lane_align u_lane_align (
        .funct3     (cur_f3),
        .addr_lo    (cur_addr[1:0]),
        .is_store   (cur_wr),
        .store_data (cur_data),
        .ram_word   (ram_word),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_data  (load_data),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    // RAM array is never reset; commit a clean store on the edge entering RESP
    always_ff @(posedge clk_w_i) begin
        if (!res_w_i_h && enter_resp && !access_fault && cur_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) ram[idx][b*8 +: 8] <= store_word[b*8 +: 8];
            end
        end
    end

    // Request FSM with registered response outputs
    always_ff @(posedge clk_w_i or posedge res_w_i_h) begin
        if (res_w_i_h) begin
            state              <= S_IDLE;
            wait_cnt           <= 3'd0;
            addr_q             <= 32'd0;
            data_q             <= 32'd0;
            f3_q               <= 3'd0;
            rd_q               <= 1'b0;
            wr_q               <= 1'b0;
            mem_data_w_o       <= 32'd0;
            mem_ready_w_o_h    <= 1'b0;
            mem_fault_w_o_h    <= 1'b0;
            fault_sticky_w_o_h <= 1'b0;
        end else begin
            mem_ready_w_o_h <= 1'b0;
            mem_fault_w_o_h <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_q <= mem_addr_w_i;
                        data_q <= mem_data_w_i;
                        f3_q   <= mem_funct3_w_i;
                        rd_q   <= mem_rd_w_i_h;
                        wr_q   <= mem_wr_w_i_h;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 3'd0) state <= S_RESP;
                    else                  wait_cnt <= wait_cnt - 3'd1;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (enter_resp) begin
                mem_ready_w_o_h <= 1'b1;
                if (access_fault) begin
                    mem_fault_w_o_h    <= 1'b1;
                    fault_sticky_w_o_h <= 1'b1;
                    mem_data_w_o       <= 32'd0;
                end else if (cur_rd) begin
                    mem_data_w_o <= load_data;
                end
            end
        end
    end

`ifdef DMEM_STATS_EN
    // Count completed accesses during RESP; a faulted access counts only as a fault
    always_ff @(posedge clk_w_i or posedge res_w_i_h) begin
        if (res_w_i_h) begin
            rd_cnt_w_o    <= 32'd0;
            wr_cnt_w_o    <= 32'd0;
            fault_cnt_w_o <= 32'd0;
        end else if (state == S_RESP) begin
            if (mem_fault_w_o_h) begin
                if (fault_cnt_w_o != 32'hFFFF_FFFF) fault_cnt_w_o <= fault_cnt_w_o + 32'd1;
            end else if (rd_q) begin
                if (rd_cnt_w_o != 32'hFFFF_FFFF) rd_cnt_w_o <= rd_cnt_w_o + 32'd1;
            end else if (wr_q) begin
                if (wr_cnt_w_o != 32'hFFFF_FFFF) wr_cnt_w_o <= wr_cnt_w_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) checked against a byte-addressed memory model.
// Latency: expected ready cycle tracked per request.
// Backpressure: requests held until ready, as the core would.
module tb_dmem_responder;

    localparam int WC [2] = '{0, 3};

    typedef struct {
        logic [31:0] data;
        logic        fault;
        logic        chk;
        logic        rd;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] addr   [2];
    logic [31:0] wdat   [2];
    logic        wr     [2];
    logic        rd     [2];
    logic [2:0]  f3     [2];
    logic [31:0] data_o [2];
    logic        ready  [2];
    logic        fault  [2];
    logic        sticky [2];
`ifdef DMEM_STATS_EN
    logic [31:0] rd_cnt [2];
    logic [31:0] wr_cnt [2];
    logic [31:0] flt_cnt[2];
`endif

    int          vectors;
    int          miscompares;
    int          cyc;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mmem [2][1024];
    logic        m_sticky [2];
    int          m_rd [2];
    int          m_wr [2];
    int          m_flt[2];
    logic [31:0] last_data [2];
    logic        last_fault[2];

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk_w_i(clk), .res_w_i_h(rst),
        .mem_addr_w_i(addr[0]), .mem_data_w_i(wdat[0]), .mem_wr_w_i_h(wr[0]),
        .mem_rd_w_i_h(rd[0]), .mem_funct3_w_i(f3[0]),
        .mem_data_w_o(data_o[0]), .mem_ready_w_o_h(ready[0]),
        .mem_fault_w_o_h(fault[0]), .fault_sticky_w_o_h(sticky[0])
`ifdef DMEM_STATS_EN
        , .rd_cnt_w_o(rd_cnt[0]), .wr_cnt_w_o(wr_cnt[0]), .fault_cnt_w_o(flt_cnt[0])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk_w_i(clk), .res_w_i_h(rst),
        .mem_addr_w_i(addr[1]), .mem_data_w_i(wdat[1]), .mem_wr_w_i_h(wr[1]),
        .mem_rd_w_i_h(rd[1]), .mem_funct3_w_i(f3[1]),
        .mem_data_w_o(data_o[1]), .mem_ready_w_o_h(ready[1]),
        .mem_fault_w_o_h(fault[1]), .fault_sticky_w_o_h(sticky[1])
`ifdef DMEM_STATS_EN
        , .rd_cnt_w_o(rd_cnt[1]), .wr_cnt_w_o(wr_cnt[1]), .fault_cnt_w_o(flt_cnt[1])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d got=%h want=%h (cycle %0d)", nm, k, got, exp, cyc);
        end
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qpop(input int k);
        return (k == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    // Byte-addressed reference: what an access must do, derived from size/sign/range rules
    function automatic void model_access(input int k, input logic [31:0] a, input logic [31:0] d,
                                         input logic r, input logic w, input logic [2:0] f,
                                         output logic [31:0] ed, output logic ef);
        int          n;
        logic        sgn;
        logic [31:0] v;
        logic [31:0] b;
        n = 0;
        sgn = 1'b0;
        case (f)
            3'b000: begin n = 1; sgn = 1'b1; end
            3'b100: begin n = 1; sgn = 1'b0; end
            3'b001: begin n = 2; sgn = 1'b1; end
            3'b101: begin n = 2; sgn = 1'b0; end
            3'b010: begin n = 4; sgn = 1'b0; end
            default: n = 0;
        endcase
        ef = (n == 0) || (r && w) || (a >= 32'd4096) || (w && f[2]);
        if (n != 0 && (a % 32'(n)) != 0) ef = 1'b1;
        ed = 32'd0;
        if (!ef) begin
            if (w) begin
                for (int i = 0; i < n; i++) begin
                    b = a + 32'(i);
                    mmem[k][b >> 2][8*(b % 4) +: 8] = d[8*i +: 8];
                end
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) begin
                    b = a + 32'(i);
                    v[8*i +: 8] = mmem[k][b >> 2][8*(b % 4) +: 8];
                end
                if (sgn && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                ed = v;
            end
        end
    endfunction

    // Per-cycle compare of both instances against the pending expectations and the model state
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_sticky[k] = 1'b0;
                m_rd[k] = 0;
                m_wr[k] = 0;
                m_flt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                exp_t e;
                if (qsize(k) == 0) begin
                    chk("ready_when_idle", k, {31'd0, ready[k]}, 32'd0);
                end else if (ready[k]) begin
                    e = qpop(k);
                    chk("ready_latency", k, 32'(cyc), 32'(e.due));
                    chk("fault_pulse", k, {31'd0, fault[k]}, {31'd0, e.fault});
                    if (e.chk || e.fault) chk("load_data", k, data_o[k], e.data);
                    m_sticky[k] = m_sticky[k] | e.fault;
                    if (e.fault)     m_flt[k]++;
                    else if (e.rd)   m_rd[k]++;
                    else             m_wr[k]++;
                    last_data[k]  = data_o[k];
                    last_fault[k] = fault[k];
                end else begin
                    chk("fault_without_ready", k, {31'd0, fault[k]}, 32'd0);
                end
                chk("sticky", k, {31'd0, sticky[k]}, {31'd0, m_sticky[k]});
            end
        end
    end

    // One requester transaction: model it, present it, hold until the response is seen
    task automatic access(input int k, input logic [31:0] a, input logic [31:0] d, input logic r,
                          input logic w, input logic [2:0] f, output logic [31:0] got, output logic gflt);
        exp_t e;
        bit   done;
        model_access(k, a, d, r, w, f, e.data, e.fault);
        e.chk = r && !w;
        e.rd  = r;
        @(negedge clk);
        addr[k] = a; wdat[k] = d; rd[k] = r; wr[k] = w; f3[k] = f;
        @(posedge clk);
        #1;
        e.due = cyc + WC[k];
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            #1;
            if (qsize(k) == 0) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL response_timeout inst%0d addr=%h no ready within 30 cycles", k, a);
            if (k == 0) q0.delete();
            else        q1.delete();
        end
        rd[k] = 1'b0; wr[k] = 1'b0;
        got  = last_data[k];
        gflt = last_fault[k];
    endtask

    initial begin
        logic [31:0] g;
        logic        gf;
        vectors = 0; miscompares = 0; cyc = 0;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            addr[k] = 0; wdat[k] = 0; wr[k] = 0; rd[k] = 0; f3[k] = 0;
            last_data[k] = 0; last_fault[k] = 0; m_sticky[k] = 0;
            m_rd[k] = 0; m_wr[k] = 0; m_flt[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_ready", k, {31'd0, ready[k]}, 32'd0);
            chk("reset_data", k, data_o[k], 32'd0);
            chk("reset_sticky", k, {31'd0, sticky[k]}, 32'd0);
        end
        #2 rst = 1'b0;

        for (int k = 0; k < 2; k++) begin
            access(k, 32'h10, 32'hDEADBEEF, 0, 1, 3'b010, g, gf);
            access(k, 32'h10, 32'h0, 1, 0, 3'b010, g, gf);
            chk("lw_after_sw", k, g, 32'hDEADBEEF);
            access(k, 32'h13, 32'h12345680, 0, 1, 3'b000, g, gf);
            access(k, 32'h13, 32'h0, 1, 0, 3'b000, g, gf);
            chk("lb_sign", k, g, 32'hFFFFFF80);
            access(k, 32'h13, 32'h0, 1, 0, 3'b100, g, gf);
            chk("lbu_zero", k, g, 32'h00000080);
            access(k, 32'h10, 32'h0, 1, 0, 3'b010, g, gf);
            chk("lw_after_sb", k, g, 32'h80ADBEEF);
            access(k, 32'h12, 32'hAAAA1234, 0, 1, 3'b001, g, gf);
            access(k, 32'h12, 32'h0, 1, 0, 3'b001, g, gf);
            chk("lh", k, g, 32'h00001234);
            access(k, 32'h11, 32'h0, 1, 0, 3'b001, g, gf);
            chk("lh_misaligned_fault", k, {31'd0, gf}, 32'd1);
            chk("lh_misaligned_data", k, g, 32'd0);
            access(k, 32'h10, 32'h0, 1, 0, 3'b010, g, gf);
            chk("lw_after_sh", k, g, 32'h1234BEEF);
            access(k, 32'h0, 32'h0BADF00D, 0, 1, 3'b010, g, gf);
            access(k, 32'h1000, 32'h55555555, 0, 1, 3'b010, g, gf);
            chk("sw_out_of_range", k, {31'd0, gf}, 32'd1);
            access(k, 32'h0, 32'hFFFFFFFF, 1, 1, 3'b010, g, gf);
            chk("rd_wr_both", k, {31'd0, gf}, 32'd1);
            access(k, 32'h0, 32'hFFFFFFFF, 0, 1, 3'b101, g, gf);
            access(k, 32'h4, 32'h0, 1, 0, 3'b011, g, gf);
            access(k, 32'h0, 32'h0, 1, 0, 3'b010, g, gf);
            chk("mem_unchanged", k, g, 32'h0BADF00D);
            chk("sticky_set", k, {31'd0, sticky[k]}, 32'd1);
        end

        // Asynchronous reset in mid-cycle clears the outputs at once
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_ready", k, {31'd0, ready[k]}, 32'd0);
            chk("async_rst_fault", k, {31'd0, fault[k]}, 32'd0);
            chk("async_rst_sticky", k, {31'd0, sticky[k]}, 32'd0);
            chk("async_rst_data", k, data_o[k], 32'd0);
        end
        @(negedge clk);
        #2 rst = 1'b0;

        // Reset during the wait states of a store: nothing committed, no response
        access(1, 32'h20, 32'h11111111, 0, 1, 3'b010, g, gf);
        @(negedge clk);
        addr[1] = 32'h20; wdat[1] = 32'h1; wr[1] = 1'b1; f3[1] = 3'b010;
        @(posedge clk);
        @(negedge clk);
        #2;
        wr[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (8) @(negedge clk);
        access(1, 32'h20, 32'h0, 1, 0, 3'b010, g, gf);
        chk("reset_mid_wait_no_commit", 1, g, 32'h11111111);
        access(0, 32'h10, 32'h0, 1, 0, 3'b010, g, gf);
        chk("ram_survives_reset", 0, g, 32'h1234BEEF);
        repeat (4) @(negedge clk);
`ifdef DMEM_STATS_EN
        for (int k = 0; k < 2; k++) begin
            chk("rd_cnt", k, rd_cnt[k], 32'(m_rd[k]));
            chk("wr_cnt", k, wr_cnt[k], 32'(m_wr[k]));
            chk("fault_cnt", k, flt_cnt[k], 32'(m_flt[k]));
        end
        chk("rd_cnt_literal", 1, rd_cnt[1], 32'd1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
